count_connected_input_feeder: RTL and testbench

- Input-side buffer placed directly upstream of the pipelined connected-count core.
- Accepts graphs and their extra data from the job distributor through a valid/ready FIFO.
- Answers each core request with a fixed-latency response of exactly DATA_IN_LATENCY cycles, which is the same latency the core's loop-back delays are built around.
- On a starved request it returns an all-zero graph with available=0, because the core requires graphIn==0 whenever graphInAvailable==0.

---
 rtl/count_connected_input_feeder.sv | 112 +++++++++++
 tb/tb_count_connected_input_feeder.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/count_connected_input_feeder.sv
// Input-side buffer for the connected-count core.
// Graphs arrive from the job distributor through a valid/ready FIFO.
// Each core request gets exactly one response, DATA_IN_LATENCY cycles later.
// A starved request produces an all-zero response with available=0.
module count_connected_input_feeder #(
  parameter int DEPTH            = 16,
  parameter int EXTRA_DATA_WIDTH = 10,
  parameter int DATA_IN_LATENCY  = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [127:0]                writeGraph,
  input  logic [EXTRA_DATA_WIDTH-1:0] writeExtraData,
  input  logic                        writeValid,
  output logic                        writeReady,
  input  logic                        request,
  output logic [127:0]                graphIn,
  output logic                        graphInAvailable,
  output logic [EXTRA_DATA_WIDTH-1:0] extraDataIn,
  output logic [$clog2(DEPTH):0]      occupancy,
  output logic [31:0]                 starvedCount
);

  localparam int PTR_W  = $clog2(DEPTH);
  localparam int OCC_W  = PTR_W + 1;
  localparam int DATA_W = 128 + EXTRA_DATA_WIDTH;

  logic [DATA_W-1:0]          mem [DEPTH];
  logic [PTR_W-1:0]           wrPtr;
  logic [PTR_W-1:0]           rdPtr;
  logic [OCC_W-1:0]           occCount;
  logic [31:0]                starvedCountReg;
  logic [DATA_IN_LATENCY-1:0] stageValid;
  logic [DATA_W-1:0]          stageData [DATA_IN_LATENCY];

  logic doPush;
  logic doPop;
  logic doStarve;

  // Ready depends only on the registered occupancy, so a pop while full
  // frees space one cycle later rather than combinationally.
  assign writeReady = (occCount != OCC_W'(DEPTH));
  assign doPush     = writeValid & writeReady;
  assign doPop      = request & (occCount != '0);
  assign doStarve   = request & (occCount == '0);

  assign occupancy        = occCount;
  assign starvedCount     = starvedCountReg;
  assign graphInAvailable = stageValid[DATA_IN_LATENCY-1];
  assign graphIn          = stageData[DATA_IN_LATENCY-1][DATA_W-1:EXTRA_DATA_WIDTH];
  assign extraDataIn      = stageData[DATA_IN_LATENCY-1][EXTRA_DATA_WIDTH-1:0];

  // Storage write; the array itself needs no reset since occupancy guards reads.
  always_ff @(posedge clk) begin
    if (rst && doPush) begin
      mem[wrPtr] <= {writeGraph, writeExtraData};
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (!rst) begin
      wrPtr <= '0;
      rdPtr <= '0;
    end else begin
      if (doPush) wrPtr <= wrPtr + PTR_W'(1);
      if (doPop)  rdPtr <= rdPtr + PTR_W'(1);
    end
  end

  // Occupancy counter kept separately from the pointers (0..DEPTH inclusive).
  always_ff @(posedge clk) begin
    if (!rst) begin
      occCount <= '0;
    end else begin
      unique case ({doPush, doPop})
        2'b10:   occCount <= occCount + OCC_W'(1);
        2'b01:   occCount <= occCount - OCC_W'(1);
        default: occCount <= occCount;
      endcase
    end
  end

  // Saturating count of requests that found the FIFO empty.
  always_ff @(posedge clk) begin
    if (!rst) begin
      starvedCountReg <= '0;
    end else if (doStarve && (starvedCountReg != '1)) begin
      starvedCountReg <= starvedCountReg + 32'd1;
    end
  end

  // Response delay line. Stage 0 holds the storage read, so any RAM read
  // latency lives inside the DATA_IN_LATENCY budget. Starved tokens travel
  // as all-zero entries, which look identical to idle cycles downstream.
  always_ff @(posedge clk) begin
    if (!rst) begin
      stageValid <= '0;
      for (int i = 0; i < DATA_IN_LATENCY; i++) begin
        stageData[i] <= '0;
      end
    end else begin
      stageValid[0] <= doPop;
      stageData[0]  <= doPop ? mem[rdPtr] : '0;
      for (int i = 1; i < DATA_IN_LATENCY; i++) begin
        stageValid[i] <= stageValid[i-1];
        stageData[i]  <= stageData[i-1];
      end
    end
  end

endmodule

// File: tb/tb_count_connected_input_feeder.sv
// Directed bench for count_connected_input_feeder.
// Inputs are driven and outputs sampled on the falling edge.
module tb_count_connected_input_feeder;

  localparam int DEPTH = 16;
  localparam int EW    = 10;
  localparam int LAT   = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [127:0]  writeGraph;
  logic [EW-1:0] writeExtraData;
  logic          writeValid;
  logic          writeReady;
  logic          request;
  logic [127:0]  graphIn;
  logic          graphInAvailable;
  logic [EW-1:0] extraDataIn;
  logic [4:0]    occupancy;
  logic [31:0]   starvedCount;

  int errCount   = 0;
  int checkCount = 0;

  count_connected_input_feeder #(
    .DEPTH(DEPTH), .EXTRA_DATA_WIDTH(EW), .DATA_IN_LATENCY(LAT)
  ) dut (
    .clk(clk), .rst(rst),
    .writeGraph(writeGraph), .writeExtraData(writeExtraData),
    .writeValid(writeValid), .writeReady(writeReady),
    .request(request),
    .graphIn(graphIn), .graphInAvailable(graphInAvailable),
    .extraDataIn(extraDataIn),
    .occupancy(occupancy), .starvedCount(starvedCount)
  );

  always #5 clk = ~clk;

  // Compare one observed value against its expected value.
  task automatic checkVal(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checkCount++;
    if (got !== exp) begin
      errCount++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cycle();
    @(negedge clk);
  endtask

  // Request is already driven; walk LAT cycles, then check the response pulse.
  task automatic expectResp(input string tag, input logic expAvail,
                            input logic [127:0] expGraph, input logic [EW-1:0] expExtra);
    for (int k = 1; k <= LAT; k++) begin
      cycle();
      request    = 1'b0;
      writeValid = 1'b0;
      if (k < LAT) checkVal({tag, "_early"}, graphInAvailable, 1'b0);
    end
    checkVal({tag, "_avail"}, graphInAvailable, expAvail);
    checkVal({tag, "_graph"}, graphIn, expGraph);
    checkVal({tag, "_extra"}, extraDataIn, expExtra);
    cycle();
    checkVal({tag, "_after"}, {graphInAvailable, graphIn, extraDataIn}, '0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int nextPush;
    rst = 1'b0; writeGraph = '0; writeExtraData = '0; writeValid = 1'b0; request = 1'b0;

    // Reset then idle
    repeat (5) cycle();
    rst = 1'b1;
    checkVal("rst_occ", occupancy, 5'd0);
    checkVal("rst_ready", writeReady, 1'b1);
    checkVal("rst_starved", starvedCount, 32'd0);
    for (int i = 0; i < 4; i++) begin
      cycle();
      checkVal("idle_out", {graphInAvailable, graphIn, extraDataIn}, '0);
    end

    // Single job
    writeGraph = 128'h1; writeExtraData = 10'h2A; writeValid = 1'b1;
    cycle();
    writeValid = 1'b0;
    checkVal("single_occ1", occupancy, 5'd1);
    request = 1'b1;
    expectResp("single", 1'b1, 128'h1, 10'h2A);
    checkVal("single_occ0", occupancy, 5'd0);

    // Starve with simultaneous push
    request = 1'b1; writeValid = 1'b1; writeGraph = 128'hF; writeExtraData = 10'h3;
    expectResp("starve", 1'b0, 128'h0, 10'h0);
    checkVal("starve_cnt", starvedCount, 32'd1);
    checkVal("starve_occ", occupancy, 5'd1);
    request = 1'b1;
    expectResp("after_starve", 1'b1, 128'hF, 10'h3);

    // Fill to full
    for (int i = 1; i <= 16; i++) begin
      writeValid = 1'b1; writeGraph = 128'(i); writeExtraData = EW'(i);
      cycle();
    end
    checkVal("full_occ", occupancy, 5'd16);
    checkVal("full_ready", writeReady, 1'b0);
    writeGraph = 128'd17; writeExtraData = EW'(17);
    cycle();
    cycle();
    checkVal("full_hold_occ", occupancy, 5'd16);

    // 20 back-to-back requests while refilling 17..20
    nextPush = 17;
    for (int c = 0; c < 24; c++) begin
      logic acc;
      request        = (c < 20);
      writeValid     = (nextPush <= 20);
      writeGraph     = 128'(nextPush);
      writeExtraData = EW'(nextPush);
      if (c == 0) checkVal("wrap_ready_c0", writeReady, 1'b0);
      if (c == 1) checkVal("wrap_ready_c1", writeReady, 1'b1);
      acc = writeValid & writeReady;
      cycle();
      if (acc) nextPush++;
      if (c >= LAT - 1 && c < 20 + LAT - 1) begin
        checkVal("wrap_avail", graphInAvailable, 1'b1);
        checkVal("wrap_graph", graphIn, 128'(c - LAT + 2));
      end else begin
        checkVal("wrap_idle", graphInAvailable, 1'b0);
      end
    end
    request = 1'b0; writeValid = 1'b0;
    checkVal("wrap_pushed", nextPush, 21);
    checkVal("wrap_occ", occupancy, 5'd0);
    checkVal("wrap_starved", starvedCount, 32'd1);

    // Mid-flight reset
    for (int i = 1; i <= 3; i++) begin
      writeValid = 1'b1; writeGraph = 128'(100 + i); writeExtraData = EW'(i);
      cycle();
    end
    writeValid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      request = 1'b1;
      cycle();
      checkVal("mid_avail", graphInAvailable, 1'b0);
    end
    request = 1'b0;
    rst = 1'b0;
    for (int i = 0; i < 2; i++) begin
      cycle();
      checkVal("mid_rst_avail", graphInAvailable, 1'b0);
    end
    rst = 1'b1;
    for (int i = 0; i < 8; i++) begin
      cycle();
      checkVal("mid_post_avail", graphInAvailable, 1'b0);
    end
    checkVal("mid_occ", occupancy, 5'd0);
    checkVal("mid_starved", starvedCount, 32'd0);

    // Saturation from a preloaded counter value
    force dut.starvedCountReg = 32'hFFFF_FFFD;
    cycle();
    release dut.starvedCountReg;
    cycle();
    checkVal("sat_preload", starvedCount, 32'hFFFF_FFFD);
    request = 1'b1;
    cycle();
    checkVal("sat_1", starvedCount, 32'hFFFF_FFFE);
    cycle();
    checkVal("sat_2", starvedCount, 32'hFFFF_FFFF);
    cycle();
    checkVal("sat_3", starvedCount, 32'hFFFF_FFFF);
    request = 1'b0;
    repeat (LAT + 1) cycle();
    checkVal("sat_out", {graphInAvailable, graphIn, extraDataIn}, '0);

    $display("Result: errors=%0d of %0d checks", errCount, checkCount);
    $finish;
  end

endmodule
